// File: rtl/fm_check_pkg.sv
// Shared types and helpers for the multi-channel first_match delay-window checker.
package fm_check_pkg;

  typedef logic [7:0] age_t;

  typedef struct packed {
    logic valid;
    age_t age;
  } slot_t;

  localparam int CNT_W = 32;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/fm_check_chan.sv
// One checker channel: attempt slots, |=> pending register, lowest-free allocator,
// first-match retirement, and per-cycle pass/fail counts for the global tallies.
module fm_check_chan
  import fm_check_pkg::*;
#(
  parameter int MIN_DLY = 0,
  parameter int MAX_DLY = 10,
  parameter int DEPTH   = 4,
  parameter int NONOVL  = 0,
  parameter int CW      = $clog2(DEPTH + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  input  logic          expr,
  output logic          pass,
  output logic          fail,
  output logic          ovf,
  output logic          busy,
  output logic [CW-1:0] pass_cnt,
  output logic [CW-1:0] fail_cnt
);

  localparam age_t MAX_AGE = age_t'(MAX_DLY);

  slot_t slot_q [DEPTH];
  slot_t slot_d [DEPTH];
  logic  pend_q, pend_d;
  logic  ovf_q, ovf_d;
  logic  pass_q, pass_d;
  logic  fail_q, fail_d;
  logic  busy_q, busy_d;
  logic  start;
  logic  have_free;
  int    free_idx;

  function automatic logic in_window(input age_t a);
    return (int'(a) >= MIN_DLY) && (int'(a) <= MAX_DLY);
  endfunction

  always_comb begin
    slot_d    = slot_q;
    pend_d    = trig;
    ovf_d     = ovf_q;
    pass_cnt  = '0;
    fail_cnt  = '0;
    have_free = 1'b0;
    free_idx  = 0;
    busy_d    = 1'b0;
    start     = (NONOVL != 0) ? pend_q : trig;

    // Free slots are judged on the current occupancy; retirements free up next cycle.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (!slot_q[k].valid) begin
        have_free = 1'b1;
        free_idx  = k;
      end
    end

    for (int k = 0; k < DEPTH; k++) begin
      if (slot_q[k].valid) begin
        if (in_window(slot_q[k].age) && expr) begin
          pass_cnt           = pass_cnt + CW'(1);
          slot_d[k].valid    = 1'b0;
        end else if (slot_q[k].age == MAX_AGE) begin
          fail_cnt           = fail_cnt + CW'(1);
          slot_d[k].valid    = 1'b0;
        end else begin
          slot_d[k].age      = slot_q[k].age + age_t'(1);
        end
      end
    end

    // A new attempt is evaluated at age 0 now; it only takes a slot if it stays live.
    if (start) begin
      if ((MIN_DLY == 0) && expr) begin
        pass_cnt = pass_cnt + CW'(1);
      end else if (MAX_DLY == 0) begin
        fail_cnt = fail_cnt + CW'(1);
      end else if (have_free) begin
        slot_d[free_idx].valid = 1'b1;
        slot_d[free_idx].age   = age_t'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    for (int k = 0; k < DEPTH; k++) begin
      busy_d = busy_d | slot_d[k].valid;
    end
    pass_d = (pass_cnt != '0);
    fail_d = (fail_cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot_q[k] <= '0;
      end
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      busy_q <= busy_d;
    end
  end

  assign pass = pass_q;
  assign fail = fail_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;

endmodule

// File: rtl/fm_check_mc.sv
// Multi-channel trig |-> first_match(##[MIN_DLY:MAX_DLY] expr) checker (|=> when NONOVL=1).
// Define FM_CHECK_TOTALS_EN to build the saturating pass_total/fail_total counters.
module fm_check_mc
  import fm_check_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MIN_DLY = 0,
  parameter int MAX_DLY = 10,
  parameter int DEPTH   = 4,
  parameter int NONOVL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   trig,
  input  logic [NCH-1:0]   expr,
  output logic [NCH-1:0]   pass,
  output logic [NCH-1:0]   fail,
  output logic [NCH-1:0]   ovf,
  output logic [NCH-1:0]   busy,
  output logic [CNT_W-1:0] pass_total,
  output logic [CNT_W-1:0] fail_total
);

  localparam int CW = $clog2(DEPTH + 2);

  logic [CW-1:0] pcnt_w [NCH];
  logic [CW-1:0] fcnt_w [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    fm_check_chan #(
      .MIN_DLY(MIN_DLY),
      .MAX_DLY(MAX_DLY),
      .DEPTH  (DEPTH),
      .NONOVL (NONOVL),
      .CW     (CW)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .trig    (trig[g]),
      .expr    (expr[g]),
      .pass    (pass[g]),
      .fail    (fail[g]),
      .ovf     (ovf[g]),
      .busy    (busy[g]),
      .pass_cnt(pcnt_w[g]),
      .fail_cnt(fcnt_w[g])
    );
  end

`ifdef FM_CHECK_TOTALS_EN
  logic [CNT_W-1:0] pass_total_q, pass_total_d;
  logic [CNT_W-1:0] fail_total_q, fail_total_d;
  logic [CNT_W-1:0] psum, fsum;

  always_comb begin
    psum = '0;
    fsum = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      psum = psum + CNT_W'(pcnt_w[ch]);
      fsum = fsum + CNT_W'(fcnt_w[ch]);
    end
    pass_total_d = sat_add(pass_total_q, psum);
    fail_total_d = sat_add(fail_total_q, fsum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_total_q <= '0;
      fail_total_q <= '0;
    end else begin
      pass_total_q <= pass_total_d;
      fail_total_q <= fail_total_d;
    end
  end

  assign pass_total = pass_total_q;
  assign fail_total = fail_total_q;
`else
  // Counts have no consumer in this build; fold them into a dead sink.
  logic unused_cnt;
  always_comb begin
    unused_cnt = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      unused_cnt = unused_cnt ^ (^{pcnt_w[ch], fcnt_w[ch]});
    end
  end

  assign pass_total = '0;
  assign fail_total = '0;
`endif

endmodule

// File: tb/tb_fm_check_mc.sv
// Bench for fm_check_mc: five parameterisations driven from shared inputs, directed
// vector table plus randomized traffic against an attempt-list reference model.
module tb_fm_check_mc;

  localparam int NI = 5;
  localparam int P_MIN   [NI] = '{0, 2, 0, 0, 1};
  localparam int P_MAX   [NI] = '{10, 5, 3, 10, 10};
  localparam int P_DEPTH [NI] = '{4, 4, 4, 4, 2};
  localparam int P_NOVL  [NI] = '{0, 0, 0, 1, 0};

  logic       clk;
  logic       rst_i;
  logic [3:0] trig_i, expr_i;
  logic [3:0]  o_pass [NI];
  logic [3:0]  o_fail [NI];
  logic [3:0]  o_ovf  [NI];
  logic [3:0]  o_busy [NI];
  logic [31:0] o_ptot [NI];
  logic [31:0] o_ftot [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fm_check_mc #(
      .NCH(4), .MIN_DLY(P_MIN[g]), .MAX_DLY(P_MAX[g]),
      .DEPTH(P_DEPTH[g]), .NONOVL(P_NOVL[g])
    ) dut (
      .clk(clk), .rst(rst_i), .trig(trig_i), .expr(expr_i),
      .pass(o_pass[g]), .fail(o_fail[g]), .ovf(o_ovf[g]), .busy(o_busy[g]),
      .pass_total(o_ptot[g]), .fail_total(o_ftot[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each channel keeps a list of live attempt ages.
  int     mage  [NI][4][8];
  bit     mlive [NI][4][8];
  bit     mpend [NI][4];
  bit     movf  [NI][4];
  bit     e_pass [NI][4];
  bit     e_fail [NI][4];
  bit     e_busy [NI][4];
  longint tot_p [NI];
  longint tot_f [NI];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int i, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d ch%0d: got %0h, expected %0h (t=%0t)", nm, i, c, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      longint sp, sf;
      sp = 0;
      sf = 0;
      for (int c = 0; c < 4; c++) begin
        int np, nf, occ;
        bit st, placed;
        np = 0; nf = 0; occ = 0; placed = 0;
        if (rst_i) begin
          for (int k = 0; k < 8; k++) mlive[i][c][k] = 0;
          mpend[i][c] = 0;
          movf[i][c]  = 0;
        end else begin
          st = (P_NOVL[i] != 0) ? mpend[i][c] : trig_i[c];
          mpend[i][c] = trig_i[c];
          for (int k = 0; k < P_DEPTH[i]; k++) begin
            if (mlive[i][c][k]) begin
              occ++;
              if (mage[i][c][k] >= P_MIN[i] && mage[i][c][k] <= P_MAX[i] && expr_i[c]) begin
                np++; mlive[i][c][k] = 0;
              end else if (mage[i][c][k] == P_MAX[i]) begin
                nf++; mlive[i][c][k] = 0;
              end else begin
                mage[i][c][k]++;
              end
            end
          end
          if (st) begin
            if (P_MIN[i] == 0 && expr_i[c]) np++;
            else if (P_MAX[i] == 0) nf++;
            else if (occ < P_DEPTH[i]) begin
              for (int k = 0; k < P_DEPTH[i]; k++) begin
                if (!placed && !mlive[i][c][k]) begin
                  mlive[i][c][k] = 1; mage[i][c][k] = 1; placed = 1;
                end
              end
            end else movf[i][c] = 1;
          end
        end
        e_pass[i][c] = (np > 0);
        e_fail[i][c] = (nf > 0);
        e_busy[i][c] = 0;
        for (int k = 0; k < 8; k++) e_busy[i][c] |= mlive[i][c][k];
        sp += np;
        sf += nf;
      end
      if (rst_i) begin
        tot_p[i] = 0; tot_f[i] = 0;
      end else begin
        tot_p[i] = (tot_p[i] + sp > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : tot_p[i] + sp;
        tot_f[i] = (tot_f[i] + sf > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : tot_f[i] + sf;
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < NI; i++) begin
      logic [31:0] xp, xf;
`ifdef FM_CHECK_TOTALS_EN
      xp = tot_p[i][31:0];
      xf = tot_f[i][31:0];
`else
      xp = 32'd0;
      xf = 32'd0;
`endif
      for (int c = 0; c < 4; c++) begin
        chk("pass", i, c, {31'd0, o_pass[i][c]}, {31'd0, e_pass[i][c]});
        chk("fail", i, c, {31'd0, o_fail[i][c]}, {31'd0, e_fail[i][c]});
        chk("ovf",  i, c, {31'd0, o_ovf[i][c]},  {31'd0, movf[i][c]});
        chk("busy", i, c, {31'd0, o_busy[i][c]}, {31'd0, e_busy[i][c]});
      end
      chk("pass_total", i, 0, o_ptot[i], xp);
      chk("fail_total", i, 0, o_ftot[i], xf);
    end
  endtask

  task automatic step(input bit r, input logic [3:0] t, input logic [3:0] e);
    rst_i  = r;
    trig_i = t;
    expr_i = e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  // Directed vectors on channel 0: inputs this cycle, outputs seen after the edge.
  typedef struct {
    int inst;
    bit r, t, e;
    bit xp, xf, xb, xo;
  } vec_t;
  vec_t vq[$];

  task automatic addv(input int inst, input bit r, input bit t, input bit e,
                      input bit xp, input bit xf, input bit xb, input bit xo);
    vec_t v;
    v = '{inst, r, t, e, xp, xf, xb, xo};
    vq.push_back(v);
  endtask

  initial begin
    rst_i = 1'b1; trig_i = '0; expr_i = '0;

    // Immediate match: pulse next cycle, no slot used.
    addv(0, 1, 0, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 1, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 0);
    // MIN=2: early expr ignored, first in-window match passes.
    addv(1, 1, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 1, 0, 0, 0, 1, 0);
    addv(1, 0, 0, 1, 0, 0, 1, 0);
    addv(1, 0, 0, 0, 0, 0, 1, 0);
    addv(1, 0, 0, 1, 1, 0, 0, 0);
    addv(1, 0, 0, 1, 0, 0, 0, 0);
    // MAX=3 timeout: fail at t+4, busy drops together with it.
    addv(2, 1, 0, 0, 0, 0, 0, 0);
    addv(2, 0, 1, 0, 0, 0, 1, 0);
    addv(2, 0, 0, 0, 0, 0, 1, 0);
    addv(2, 0, 0, 0, 0, 0, 1, 0);
    addv(2, 0, 0, 0, 0, 1, 0, 0);
    addv(2, 0, 0, 0, 0, 0, 0, 0);
    // |=>: expr at the trigger cycle does not count.
    addv(3, 1, 0, 0, 0, 0, 0, 0);
    addv(3, 0, 1, 1, 0, 0, 0, 0);
    addv(3, 0, 0, 0, 0, 0, 1, 0);
    addv(3, 0, 0, 1, 1, 0, 0, 0);
    // DEPTH=2 overflow, then both held attempts time out.
    addv(4, 1, 0, 0, 0, 0, 0, 0);
    addv(4, 0, 1, 0, 0, 0, 1, 0);
    addv(4, 0, 1, 0, 0, 0, 1, 0);
    addv(4, 0, 1, 0, 0, 0, 1, 1);
    addv(4, 0, 1, 0, 0, 0, 1, 1);
    for (int k = 0; k < 6; k++) addv(4, 0, 0, 0, 0, 0, 1, 1);
    addv(4, 0, 0, 0, 0, 1, 1, 1);
    addv(4, 0, 0, 0, 0, 1, 0, 1);
    addv(4, 0, 0, 0, 0, 0, 0, 1);
    // Reset mid-window discards attempts silently; fresh trigger works after.
    addv(0, 1, 0, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 1, 0);
    addv(0, 0, 1, 0, 0, 0, 1, 0);
    addv(0, 0, 0, 0, 0, 0, 1, 0);
    addv(0, 1, 1, 0, 0, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 0);
    addv(0, 0, 1, 1, 1, 0, 0, 0);
    addv(0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < vq.size(); n++) begin
      step(vq[n].r, {3'b000, vq[n].t}, {3'b000, vq[n].e});
      chk("tbl_pass", vq[n].inst, n, {31'd0, o_pass[vq[n].inst][0]}, {31'd0, vq[n].xp});
      chk("tbl_fail", vq[n].inst, n, {31'd0, o_fail[vq[n].inst][0]}, {31'd0, vq[n].xf});
      chk("tbl_busy", vq[n].inst, n, {31'd0, o_busy[vq[n].inst][0]}, {31'd0, vq[n].xb});
      chk("tbl_ovf",  vq[n].inst, n, {31'd0, o_ovf[vq[n].inst][0]},  {31'd0, vq[n].xo});
    end

    // Randomized traffic, alternating dense-match and sparse-match phases.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] t, e;
      bit sparse;
      sparse = ((n / 300) % 2) == 1;
      for (int c = 0; c < 4; c++) begin
        t[c] = ($urandom_range(0, 2) == 0);
        e[c] = sparse ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
      end
      step($urandom_range(0, 199) == 0, t, e);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
